obstacle_scroller: RTL
======================

// Module: obstacle_scroller
// PURPOSE
//  Drives the obstacle-pattern ROM index, latches the pattern's two start positions, and scrolls them down the track one step per video frame.
//  Retires obstacles that leave the screen, then requests the next pattern.
//  Sits between the game controller (enable/speed) and the sprite renderer (obj*_x/y).
// PARAMETERS
//  SCREEN_H   480     visible lines; y >= SCREEN_H means off-screen
//  PARK_Y     10'h262 y value marking an inactive (parked) obstacle
//  LFSR_SEED  8'hA5   non-zero LFSR reset value
//  WAVES_LVL  8       waves per speed step (SPEEDUP_EN only)
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   asynchronous active-low reset
//  enable      in   1   game running; low aborts to IDLE
//  frame_tick  in   1   one-cycle pulse per frame (vsync)
//  speed       in   4   lines moved per frame (base speed)
//  index       out  3   pattern select to position ROM, 0..5
//  rom_x0/y0   in   10  ROM obstacle-0 start position (combinational on index)
//  rom_x1/y1   in   10  ROM obstacle-1 start position
//  obj0_x/y    out  10  obstacle-0 current position
//  obj1_x/y    out  10  obstacle-1 current position
//  obj_active  out  2   bit n = obstacle n on screen (y != PARK_Y)
//  wave_count  out  8   patterns completed, wraps 255->0
// BEHAVIOUR
//  Reset: state IDLE, index=0, obj*_x=0, obj*_y=PARK_Y, obj_active=0, wave_count=0, lfsr=LFSR_SEED.
//  LFSR: 8-bit Fibonacci, taps 8,6,5,4; advances every clk; never zero.
//  FSM: IDLE -> SELECT when enable=1.
//   SELECT (1 cycle): index <= lfsr[2:0], with 6->0, 7->1; -> LOAD.
//   LOAD (1 cycle): ROM outputs settled; obj* <= rom_*; -> SCROLL.
//   SCROLL: on frame_tick, each obstacle with y != PARK_Y gets y+eff_speed (11-bit sum);
//    if sum >= SCREEN_H, y <= PARK_Y (retired). Parked obstacles untouched (ROM y=PARK_Y stays parked).
//    When both y == PARK_Y: wave_count++, -> SELECT (next cycle, tick not needed).
//  enable=0 in any state: next cycle -> IDLE, both y <= PARK_Y, x held, wave_count held.
//  frame_tick in IDLE/SELECT/LOAD is ignored (no carry-over).
//  speed=0: obstacles freeze; no retirement; FSM stays in SCROLL.
//  Pattern with both y=PARK_Y (not produced by ROM): wave completes on first SCROLL cycle.
//  obj_active is registered from the new y values (same cycle as y update).
//  Latency: enable rise -> positions valid 3 clks (IDLE,SELECT,LOAD).
// CONFIGURATION
//  OBSTACLE_SPEEDUP_EN defined: eff_speed = min(speed + level, 15); level (4b, reset 0)
//   increments every WAVES_LVL completed waves, saturates at 15; cleared when enable=0.
//  Not defined: eff_speed = speed; no level register.
// STRUCTURE
//  race_pkg: SCREEN_H, PARK_Y, lane constants LANE_L=10'hC5 / LANE_C=10'h117 / LANE_R=10'h169, FSM state encodings (2 bits).
//  Sub-module race_lfsr (8-bit, seed param, free-running); FSM and datapath in top.
// TESTING
//  1 Reset, enable=1, ROM model fed from index, force lfsr->index 0: after 3 clks obj0=(C5,0), obj1=(169,0), obj_active=11.
//  2 speed=4, 120 ticks: y=480 -> both PARK_Y, obj_active=00, wave_count=1, new index within 2 clks.
//  3 index 3 (obj1 parked), speed=7: obj1_y stays 262 throughout; wave ends when obj0 sum>=480 (tick 69).
//  4 enable low mid-SCROLL at y=200: next clk IDLE, y=262, obj_active=00; re-enable reloads fresh pattern.
//  5 frame_tick pulsed during SELECT/LOAD: first SCROLL y still equals ROM y (tick dropped); speed=0 holds y.
//  6 OBSTACLE_SPEEDUP_EN, speed=14: after 8 waves eff_speed=15 (saturated); 100 random-seed waves: index always 0..5.

Source files
------------

// File: rtl/race_pkg.sv
// race_pkg
//   Shared constants, FSM state encoding and small helpers for the
//   obstacle scroller block.
//   Contents:
//     SCREEN_H            number of visible lines (y >= SCREEN_H is off-screen)
//     PARK_Y              y value that marks a parked (inactive) obstacle
//     LANE_L/LANE_C/LANE_R  x positions of the three track lanes
//     WAVES_LVL           completed waves per speed level (speed-up build only)
//     state_e             2-bit scroller FSM state
//     foldIndex()         folds a 3-bit random value onto pattern range 0..5
//     stepY()             advances one obstacle by one frame

package race_pkg;

  localparam logic [10:0] SCREEN_H  = 11'd480;
  localparam logic [9:0]  PARK_Y    = 10'h262;

  localparam logic [9:0]  LANE_L    = 10'hC5;
  localparam logic [9:0]  LANE_C    = 10'h117;
  localparam logic [9:0]  LANE_R    = 10'h169;

  localparam int          WAVES_LVL = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SELECT = 2'd1,
    ST_LOAD   = 2'd2,
    ST_SCROLL = 2'd3
  } state_e;

  // The ROM only holds six patterns; the two spare codes are folded back
  // onto the first two so every random draw is a legal pattern.
  function automatic logic [2:0] foldIndex(input logic [2:0] raw);
    logic [2:0] folded;
    folded = raw;
    if (raw >= 3'd6) begin
      folded = raw - 3'd6;
    end
    return folded;
  endfunction

  // Moves one obstacle down by eff lines. Parked obstacles and a zero
  // speed leave y untouched; anything reaching the bottom edge is parked.
  // The sum is 11 bits wide so a y near the bottom cannot wrap around.
  function automatic logic [9:0] stepY(input logic [9:0] y,
                                       input logic [3:0] eff);
    logic [10:0] sum;
    logic [9:0]  result;
    sum    = {1'b0, y} + {7'b0, eff};
    result = y;
    if ((y != PARK_Y) && (eff != 4'd0)) begin
      if (sum >= SCREEN_H) begin
        result = PARK_Y;
      end else begin
        result = sum[9:0];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/race_lfsr.sv
// race_lfsr
//   Free-running 8-bit Fibonacci LFSR, polynomial x^8 + x^6 + x^5 + x^4 + 1
//   (maximal length, 255 states). Advances every clock out of reset and
//   can never reach zero as long as SEED is non-zero.
//   Parameters:
//     SEED     reset value, must be non-zero
//   Ports:
//     clk      in   system clock
//     rst_n    in   asynchronous active-low reset
//     value_o  out  current LFSR state

module race_lfsr #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] value_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;
  logic       feedback;

  // Taps 8,6,5,4 counted from 1 map onto bits 7,5,4,3.
  always_comb begin
    feedback = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    lfsr_d   = {lfsr_q[6:0], feedback};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value_o = lfsr_q;

endmodule

// File: rtl/obstacle_scroller.sv
// obstacle_scroller
//   Picks a random obstacle pattern, loads its two start positions from the
//   external position ROM, scrolls both obstacles down one step per video
//   frame, parks them once they leave the screen and then asks for the next
//   pattern.
//   Optional feature: define OBSTACLE_SPEEDUP_EN to add a difficulty level
//   that raises the effective speed by one line every WAVES_LVL waves
//   (saturating at 15 lines/frame). Without it the speed input is used as is.
//   Parameters:
//     LFSR_SEED   non-zero seed of the pattern-select LFSR
//   Ports:
//     clk         in   system clock
//     rst_n       in   asynchronous active-low reset
//     enable      in   game running; low aborts to IDLE and parks obstacles
//     frame_tick  in   one-cycle pulse per video frame
//     speed       in   base lines moved per frame
//     index       out  pattern select to the position ROM (0..5)
//     rom_x0/y0   in   obstacle-0 start position from the ROM
//     rom_x1/y1   in   obstacle-1 start position from the ROM
//     obj0_x/y    out  obstacle-0 current position
//     obj1_x/y    out  obstacle-1 current position
//     obj_active  out  bit n set while obstacle n is not parked
//     wave_count  out  number of completed patterns (wraps)

module obstacle_scroller
  import race_pkg::*;
#(
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic [3:0] speed,
  output logic [2:0] index,
  input  logic [9:0] rom_x0,
  input  logic [9:0] rom_y0,
  input  logic [9:0] rom_x1,
  input  logic [9:0] rom_y1,
  output logic [9:0] obj0_x,
  output logic [9:0] obj0_y,
  output logic [9:0] obj1_x,
  output logic [9:0] obj1_y,
  output logic [1:0] obj_active,
  output logic [7:0] wave_count
);

  state_e     state_q,  state_d;
  logic [2:0] index_q,  index_d;
  logic [9:0] obj0X_q,  obj0X_d;
  logic [9:0] obj0Y_q,  obj0Y_d;
  logic [9:0] obj1X_q,  obj1X_d;
  logic [9:0] obj1Y_q,  obj1Y_d;
  logic [1:0] active_q, active_d;
  logic [7:0] wave_q,   wave_d;

  logic [7:0] lfsrValue;
  logic       unusedLfsrHi;
  logic [3:0] effSpeed;
  logic       bothParked;

  race_lfsr #(
    .SEED    (LFSR_SEED)
  ) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .value_o (lfsrValue)
  );

  // Only the low three bits pick a pattern.
  assign unusedLfsrHi = ^lfsrValue[7:3];

  assign bothParked = (obj0Y_q == PARK_Y) && (obj1Y_q == PARK_Y);

`ifdef OBSTACLE_SPEEDUP_EN
  logic [3:0] level_q,  level_d;
  logic [7:0] lvlCnt_q, lvlCnt_d;
  logic [4:0] speedSum;

  // A carry out of the 4-bit add means the sum passed 15: clamp it.
  always_comb begin
    speedSum = {1'b0, speed} + {1'b0, level_q};
    effSpeed = speedSum[4] ? 4'hF : speedSum[3:0];
  end
`else
  assign effSpeed = speed;
`endif

  // Next-state logic. Dropping enable overrides everything: obstacles are
  // parked (x kept for the renderer), the wave counter is kept and the FSM
  // returns to IDLE. frame_tick is only looked at in SCROLL, so ticks seen
  // while a pattern is being selected or loaded are simply lost.
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    obj0X_d  = obj0X_q;
    obj0Y_d  = obj0Y_q;
    obj1X_d  = obj1X_q;
    obj1Y_d  = obj1Y_q;
    wave_d   = wave_q;
`ifdef OBSTACLE_SPEEDUP_EN
    level_d  = level_q;
    lvlCnt_d = lvlCnt_q;
`endif

    if (!enable) begin
      state_d = ST_IDLE;
      obj0Y_d = PARK_Y;
      obj1Y_d = PARK_Y;
`ifdef OBSTACLE_SPEEDUP_EN
      level_d  = 4'd0;
      lvlCnt_d = 8'd0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SELECT;
        end
        ST_SELECT: begin
          index_d = foldIndex(lfsrValue[2:0]);
          state_d = ST_LOAD;
        end
        ST_LOAD: begin
          // The ROM has had the whole SELECT->LOAD cycle to settle on index.
          obj0X_d = rom_x0;
          obj0Y_d = rom_y0;
          obj1X_d = rom_x1;
          obj1Y_d = rom_y1;
          state_d = ST_SCROLL;
        end
        ST_SCROLL: begin
          // Completion is checked on the registered positions, so a wave
          // ends the cycle after its last obstacle was parked, without
          // waiting for another frame.
          if (bothParked) begin
            wave_d  = wave_q + 8'd1;
            state_d = ST_SELECT;
`ifdef OBSTACLE_SPEEDUP_EN
            if (lvlCnt_q == 8'(WAVES_LVL - 1)) begin
              lvlCnt_d = 8'd0;
              if (level_q != 4'hF) begin
                level_d = level_q + 4'd1;
              end
            end else begin
              lvlCnt_d = lvlCnt_q + 8'd1;
            end
`endif
          end else if (frame_tick) begin
            obj0Y_d = stepY(obj0Y_q, effSpeed);
            obj1Y_d = stepY(obj1Y_q, effSpeed);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // The active flags follow the y values being written this cycle so the
    // renderer never sees a position and a stale flag together.
    active_d = {(obj1Y_d != PARK_Y), (obj0Y_d != PARK_Y)};
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      index_q  <= 3'd0;
      obj0X_q  <= 10'd0;
      obj0Y_q  <= PARK_Y;
      obj1X_q  <= 10'd0;
      obj1Y_q  <= PARK_Y;
      active_q <= 2'b00;
      wave_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      obj0X_q  <= obj0X_d;
      obj0Y_q  <= obj0Y_d;
      obj1X_q  <= obj1X_d;
      obj1Y_q  <= obj1Y_d;
      active_q <= active_d;
      wave_q   <= wave_d;
    end
  end

`ifdef OBSTACLE_SPEEDUP_EN
  // Difficulty level registers, only present in the speed-up build.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q  <= 4'd0;
      lvlCnt_q <= 8'd0;
    end else begin
      level_q  <= level_d;
      lvlCnt_q <= lvlCnt_d;
    end
  end
`endif

  assign index      = index_q;
  assign obj0_x     = obj0X_q;
  assign obj0_y     = obj0Y_q;
  assign obj1_x     = obj1X_q;
  assign obj1_y     = obj1Y_q;
  assign obj_active = active_q;
  assign wave_count = wave_q;

endmodule
